sequence_transmitter: RTL and testbench

Serial pattern transmitter that produces the bit stream consumed by the 1100110 sequence detector. A PAT_W-bit pattern and length are loaded from switches on a key press. Each press of the step key then emits one bit, MSB-first, on `x_out`, with optional continuous repeat. Emitted-bit history drives the LEDs, and the remaining-bit count drives one seven-segment digit.

---
 rtl/sequence_transmitter_pkg.sv | 22 ++
 rtl/sequence_transmitter_if.sv | 29 ++
 rtl/sequence_transmitter_key_pulse.sv | 51 +++++
 rtl/sequence_transmitter.sv | 119 +++++++++++
 tb/tb_sequence_transmitter.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/sequence_transmitter_pkg.sv
// Shared types and seven-segment decode for the serial pattern transmitter.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] HEX_BLANK = 8'hFF;

  // Active-low gfedcba in [6:0], decimal point [7] held off.
  localparam logic [7:0] SEG_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [7:0] seg7(input logic [3:0] v);
    return SEG_TABLE[v];
  endfunction

endpackage

// File: rtl/sequence_transmitter_if.sv
// Key, switch and display bundle between the board (master) and the transmitter (slave).
interface sequence_transmitter_if #(
  parameter int PAT_W = 8
) ();

  logic             load;
  logic             shift;
  logic [PAT_W-1:0] pattern;
  logic [3:0]       length;
  logic             repeat_en;
  logic             x_out;
  logic             bit_valid;
  logic             busy;
  logic             done;
  logic [3:0]       bit_idx;
  logic [9:0]       diods;
  logic [7:0]       HEX0;

  modport master (
    output load, shift, pattern, length, repeat_en,
    input  x_out, bit_valid, busy, done, bit_idx, diods, HEX0
  );

  modport slave (
    input  load, shift, pattern, length, repeat_en,
    output x_out, bit_valid, busy, done, bit_idx, diods, HEX0
  );

endinterface

// File: rtl/sequence_transmitter_key_pulse.sv
// Active-low key conditioner: 2-FF synchronizer, debounce filter, one-cycle press pulse.
module key_pulse #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter runs only while the synced level disagrees with the accepted one.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
        press_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= key_ni;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/sequence_transmitter.sv
// Serial pattern transmitter: load a pattern from switches, emit one bit MSB-first per step key press.
module sequence_transmitter
  import seq_pkg::*;
#(
  parameter int PAT_W           = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input logic                  CLOCK_50,
  input logic                  rst,
  sequence_transmitter_if.slave bus
);

  logic load_p, step_p;

  key_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_key (
    .clk_i   (CLOCK_50),
    .rst_ni  (rst),
    .key_ni  (bus.load),
    .press_o (load_p)
  );

  key_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_shift_key (
    .clk_i   (CLOCK_50),
    .rst_ni  (rst),
    .key_ni  (bus.shift),
    .press_o (step_p)
  );

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [3:0]       len_q, len_d;
  logic [3:0]       idx_q, idx_d;
  logic             x_q, x_d;
  logic             bv_q, bv_d;
  logic             done_q, done_d;
  logic [9:0]       diods_q, diods_d;

  logic [15:0] pat_ext;
  logic [3:0]  sel;
  logic        cur_bit;
  logic [3:0]  remaining;

  assign pat_ext   = 16'(pat_q);
  assign sel       = len_q - 4'd1 - idx_q;
  assign cur_bit   = pat_ext[sel];
  assign remaining = len_q - idx_q;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    x_d     = x_q;
    bv_d    = 1'b0;
    done_d  = 1'b0;
    diods_d = diods_q;
    // A zero-length load is a no-op, so a coincident step still proceeds.
    if (load_p && (bus.length != 4'd0)) begin
      pat_d   = bus.pattern;
      len_d   = (int'(bus.length) > PAT_W) ? 4'(PAT_W) : bus.length;
      idx_d   = 4'd0;
      state_d = SEND;
    end else if (step_p && (state_q == SEND)) begin
      x_d     = cur_bit;
      bv_d    = 1'b1;
      diods_d = {diods_q[8:0], cur_bit};
      if (idx_q == len_q - 4'd1) begin
        if (bus.repeat_en) begin
          idx_d = 4'd0;
        end else begin
          idx_d   = idx_q + 4'd1;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end else begin
        idx_d = idx_q + 4'd1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      x_q     <= 1'b0;
      bv_q    <= 1'b0;
      done_q  <= 1'b0;
      diods_q <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      bv_q    <= bv_d;
      done_q  <= done_d;
      diods_q <= diods_d;
    end
  end

  always_comb begin
    bus.HEX0 = HEX_BLANK;
    case (state_q)
      SEND:    bus.HEX0 = seg7(remaining);
      DONE:    bus.HEX0 = seg7(4'd0);
      default: bus.HEX0 = HEX_BLANK;
    endcase
  end

  assign bus.x_out     = x_q;
  assign bus.bit_valid = bv_q;
  assign bus.busy      = (state_q == SEND);
  assign bus.done      = done_q;
  assign bus.bit_idx   = idx_q;
  assign bus.diods     = diods_q;

endmodule

// File: tb/tb_sequence_transmitter.sv
// Scoreboard bench for sequence_transmitter with a short debounce window.
module tb_sequence_transmitter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sequence_transmitter_if #(.PAT_W(8)) bus ();

  sequence_transmitter #(.PAT_W(8), .DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50 (clk),
    .rst      (rst),
    .bus      (bus)
  );

  typedef struct {
    logic       x;
    logic       dn;
    logic [3:0] idx;
    logic [9:0] diods;
  } exp_t;

  exp_t       sb[$];
  logic [9:0] m_diods = '0;
  int         pass_cnt = 0;
  int         total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_exp(input logic b, input logic [3:0] idx, input logic dn);
    exp_t e;
    m_diods = {m_diods[8:0], b};
    e.x = b; e.dn = dn; e.idx = idx; e.diods = m_diods;
    sb.push_back(e);
  endtask

  task automatic press(input bit do_load, input bit do_step, input int low_cycles);
    @(posedge clk); #1;
    if (do_load) bus.load = 1'b0;
    if (do_step) bus.shift = 1'b0;
    repeat (low_cycles) @(posedge clk);
    #1;
    bus.load  = 1'b1;
    bus.shift = 1'b1;
    repeat (12) @(posedge clk);
    #1;
  endtask

  // Monitor: every bit_valid must match the next scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.bit_valid === 1'b1) begin
        if (sb.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_bit_valid: got 1 expected 0 at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("bit_x_out", 32'(bus.x_out), 32'(e.x));
          check("bit_done", 32'(bus.done), 32'(e.dn));
          check("bit_idx", 32'(bus.bit_idx), 32'(e.idx));
          check("bit_diods", 32'(bus.diods), 32'(e.diods));
        end
      end else if (bus.done !== 1'b0) begin
        total_cnt++;
        $display("FAIL done_without_bit: got %0b expected 0 at %0t", bus.done, $time);
      end
    end
  end

  localparam logic BITS7 [7] = '{1, 1, 0, 0, 1, 1, 0};
  localparam logic BITS_REP [9] = '{1, 1, 0, 0, 1, 1, 0, 1, 1};
  localparam logic [3:0] IDX_REP [9] = '{1, 2, 3, 4, 5, 6, 0, 1, 2};
  localparam logic BITS_A5 [8] = '{1, 0, 1, 0, 0, 1, 0, 1};

  initial begin
    bus.load = 1'b1; bus.shift = 1'b1;
    bus.pattern = 8'h66; bus.length = 4'd7; bus.repeat_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    check("rst_x_out", 32'(bus.x_out), 0);
    check("rst_bit_valid", 32'(bus.bit_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_bit_idx", 32'(bus.bit_idx), 0);
    check("rst_diods", 32'(bus.diods), 0);
    check("rst_hex", 32'(bus.HEX0), 32'h0FF);

    // Zero-length load and step in IDLE are both ignored.
    bus.length = 4'd0;
    press(1, 0, 10);
    check("len0_busy", 32'(bus.busy), 0);
    check("len0_hex", 32'(bus.HEX0), 32'h0FF);
    press(0, 1, 10);
    check("idle_step_busy", 32'(bus.busy), 0);

    // 0x66, 7 bits, no repeat.
    bus.length = 4'd7;
    press(1, 0, 10);
    check("load_busy", 32'(bus.busy), 1);
    check("load_idx", 32'(bus.bit_idx), 0);
    check("load_hex", 32'(bus.HEX0), 32'h0F8);
    check("load_x_hold", 32'(bus.x_out), 0);
    check("load_diods_hold", 32'(bus.diods), 0);
    for (int k = 0; k < 7; k++) begin
      push_exp(BITS7[k], (k == 6) ? 4'd7 : 4'(k + 1), (k == 6));
      press(0, 1, 10);
    end
    check("done_busy", 32'(bus.busy), 0);
    check("done_diods", 32'(bus.diods), 32'h066);
    check("done_hex", 32'(bus.HEX0), 32'h0C0);
    press(0, 1, 10);
    check("done_step_x", 32'(bus.x_out), 0);
    check("done_step_diods", 32'(bus.diods), 32'h066);

    // Repeat mode wraps after index 6.
    bus.repeat_en = 1'b1;
    press(1, 0, 10);
    check("rep_busy", 32'(bus.busy), 1);
    for (int k = 0; k < 9; k++) begin
      push_exp(BITS_REP[k], IDX_REP[k], 1'b0);
      press(0, 1, 10);
    end
    check("rep_idx", 32'(bus.bit_idx), 2);
    check("rep_busy_after", 32'(bus.busy), 1);
    check("rep_hex", 32'(bus.HEX0), 32'h092);
    check("rep_diods", 32'(bus.diods), 32'h19B);

    // Short bounce is filtered; a long press gives exactly one bit.
    press(0, 1, 3);
    check("bounce_idx", 32'(bus.bit_idx), 2);
    push_exp(1'b0, 4'd3, 1'b0);
    press(0, 1, 10);
    check("long_idx", 32'(bus.bit_idx), 3);
    check("long_hex", 32'(bus.HEX0), 32'h099);

    // Coincident load and step: load wins.
    press(1, 1, 10);
    check("sim_idx", 32'(bus.bit_idx), 0);
    check("sim_x", 32'(bus.x_out), 0);
    check("sim_busy", 32'(bus.busy), 1);
    check("sim_hex", 32'(bus.HEX0), 32'h0F8);

    // Length 12 clamps to 8.
    bus.repeat_en = 1'b0;
    bus.pattern = 8'hA5; bus.length = 4'd12;
    press(1, 0, 10);
    check("clamp_hex", 32'(bus.HEX0), 32'h080);
    for (int k = 0; k < 8; k++) begin
      push_exp(BITS_A5[k], (k == 7) ? 4'd8 : 4'(k + 1), (k == 7));
      press(0, 1, 10);
    end
    check("clamp_busy", 32'(bus.busy), 0);
    check("clamp_hex_done", 32'(bus.HEX0), 32'h0C0);

    // Reset mid-SEND after 4 bits.
    bus.pattern = 8'h66; bus.length = 4'd7;
    press(1, 0, 10);
    for (int k = 0; k < 4; k++) begin
      push_exp(BITS7[k], 4'(k + 1), 1'b0);
      press(0, 1, 10);
    end
    check("pre_rst_idx", 32'(bus.bit_idx), 4);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("arst_x_out", 32'(bus.x_out), 0);
    check("arst_bit_valid", 32'(bus.bit_valid), 0);
    check("arst_busy", 32'(bus.busy), 0);
    check("arst_done", 32'(bus.done), 0);
    check("arst_bit_idx", 32'(bus.bit_idx), 0);
    check("arst_diods", 32'(bus.diods), 0);
    check("arst_hex", 32'(bus.HEX0), 32'h0FF);
    m_diods = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    press(0, 1, 10);
    check("post_rst_busy", 32'(bus.busy), 0);
    check("post_rst_hex", 32'(bus.HEX0), 32'h0FF);
    check("post_rst_idx", 32'(bus.bit_idx), 0);

    repeat (4) @(posedge clk);
    check("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
